// File: rtl/ceyloniac_pkg.sv
// Shared definitions for the Ceyloniac multi-cycle memory interface:
// FSM state encodings, the default access timeout and an alignment helper.
package ceyloniac_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned TIMEOUT_DEFAULT = 15;

  function automatic logic is_word_aligned(input logic [31:0] byte_addr);
    return (byte_addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ceyloniac_mem_interface.sv
// Memory interface between a multi-cycle control unit and a word RAM with a
// ready strobe: IDLE/BUSY/DONE handshake, alignment check and access timeout.
module ceyloniac_mem_interface
  import ceyloniac_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              i_or_d,
  input  logic              ir_write,
  input  logic [31:0]       pc,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       write_data,
  input  logic [31:0]       ram_read_data,
  input  logic              ram_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_write_data,
  output logic              ram_read_enable,
  output logic              ram_write_enable,
  output logic [31:0]       instr,
  output logic [31:0]       mdr,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              addr_error,
  output logic              bus_error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic              irw_q, irw_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       mdr_q, mdr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              addr_err_q, addr_err_d;
  logic              bus_err_q, bus_err_d;

  logic [31:0] req_addr;
  logic        unused_addr_hi;

  assign req_addr       = i_or_d ? data_addr : pc;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  // NOTE: every _d gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rd_en_d     = rd_en_q;
    wr_en_d     = wr_en_q;
    irw_d       = irw_q;
    instr_d     = instr_q;
    mdr_d       = mdr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    addr_err_d  = 1'b0;
    bus_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mem_read || mem_write) begin
          if (!is_word_aligned(req_addr) || (mem_read && mem_write)) begin
            addr_err_d = 1'b1;
          end else begin
            state_d     = ST_BUSY;
            cnt_d       = '0;
            ram_addr_d  = req_addr[ADDR_W+1:2];
            ram_wdata_d = write_data;
            rd_en_d     = mem_read;
            wr_en_d     = mem_write;
            irw_d       = ir_write;
            busy_d      = 1'b1;
          end
        end
      end

      ST_BUSY: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        // ram_ready is tested first so it wins over a coincident timeout.
        if (ram_ready || (cnt_d == CNT_MAX)) begin
          state_d   = ST_DONE;
          rd_en_d   = 1'b0;
          wr_en_d   = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          bus_err_d = !ram_ready;
          if (ram_ready && rd_en_q) begin
            mdr_d = ram_read_data;
            if (irw_q) instr_d = ram_read_data;
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments only here, so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      irw_q       <= 1'b0;
      instr_q     <= '0;
      mdr_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      addr_err_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      irw_q       <= irw_d;
      instr_q     <= instr_d;
      mdr_q       <= mdr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      addr_err_q  <= addr_err_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign ram_addr         = ram_addr_q;
  assign ram_write_data   = ram_wdata_q;
  assign ram_read_enable  = rd_en_q;
  assign ram_write_enable = wr_en_q;
  assign instr            = instr_q;
  assign mdr              = mdr_q;
  assign mem_busy         = busy_q;
  assign mem_done         = done_q;
  assign addr_error       = addr_err_q;
  assign bus_error        = bus_err_q;

endmodule

// File: tb/tb_ceyloniac_mem_interface.sv
// Self-checking bench for ceyloniac_mem_interface: directed scenarios plus
// randomized transactions scored against a transaction-level model.
module tb_ceyloniac_mem_interface;

  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              mem_read, mem_write, i_or_d, ir_write;
  logic [31:0]       pc, data_addr, write_data, ram_read_data;
  logic              ram_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_write_data, instr, mdr;
  logic              ram_read_enable, ram_write_enable;
  logic              mem_busy, mem_done, addr_error, bus_error;

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural expectations for the two data registers.
  logic [31:0] exp_mdr   = '0;
  logic [31:0] exp_instr = '0;

  ceyloniac_mem_interface #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .i_or_d           (i_or_d),
    .ir_write         (ir_write),
    .pc               (pc),
    .data_addr        (data_addr),
    .write_data       (write_data),
    .ram_read_data    (ram_read_data),
    .ram_ready        (ram_ready),
    .ram_addr         (ram_addr),
    .ram_write_data   (ram_write_data),
    .ram_read_enable  (ram_read_enable),
    .ram_write_enable (ram_write_enable),
    .instr            (instr),
    .mdr              (mdr),
    .mem_busy         (mem_busy),
    .mem_done         (mem_done),
    .addr_error       (addr_error),
    .bus_error        (bus_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},  32'(mem_busy), 0);
    check({tag, "_rd_en"}, 32'(ram_read_enable), 0);
    check({tag, "_wr_en"}, 32'(ram_write_enable), 0);
    check({tag, "_done"},  32'(mem_done), 0);
    check({tag, "_mdr"},   mdr, exp_mdr);
    check({tag, "_instr"}, instr, exp_instr);
  endtask

  // One full request. k = BUSY cycle (1-based) in which ram_ready is high;
  // k > TIMEOUT means the RAM never answers.
  task automatic do_txn(input logic rd, input logic wr, input logic irw, input logic iord,
                        input logic [31:0] pcv, input logic [31:0] dav, input logic [31:0] wd,
                        input int k, input logic [31:0] rdata);
    logic [31:0]       addr;
    logic [ADDR_W-1:0] exp_ra;
    bit                err;
    addr   = iord ? dav : pcv;
    exp_ra = addr[ADDR_W+1:2];
    err    = (addr[1:0] != 2'b00) || (rd && wr);

    mem_read = rd; mem_write = wr; ir_write = irw; i_or_d = iord;
    pc = pcv; data_addr = dav; write_data = wd;
    ram_ready = 1'($urandom);           // not BUSY yet: must be ignored
    ram_read_data = $urandom;
    step();

    if (err) begin
      check("err_pulse", 32'(addr_error), 1);
      check_quiet("err");
      clear_req();
      ram_ready = 1'b0;
      step();
      check("err_pulse_end", 32'(addr_error), 0);
      check_quiet("err_after");
      return;
    end

    check("accept_busy",  32'(mem_busy), 1);
    check("accept_rd_en", 32'(ram_read_enable), 32'(rd));
    check("accept_wr_en", 32'(ram_write_enable), 32'(wr));
    check("accept_addr",  32'(ram_addr), 32'(exp_ra));
    check("accept_wdata", ram_write_data, wd);
    check("accept_noerr", 32'(addr_error), 0);

    for (int i = 1; i <= TIMEOUT; i++) begin
      // Request lines churn during BUSY and must not disturb the access.
      mem_read = 1'($urandom); mem_write = 1'($urandom); ir_write = 1'($urandom);
      i_or_d = 1'($urandom); pc = $urandom; data_addr = $urandom; write_data = $urandom;
      ram_ready     = (i == k);
      ram_read_data = (i == k) ? rdata : $urandom;
      step();
      if (i == k) begin
        if (rd) begin
          exp_mdr = rdata;
          if (irw) exp_instr = rdata;
        end
        check("cmpl_done",   32'(mem_done), 1);
        check("cmpl_buserr", 32'(bus_error), 0);
        check("cmpl_busy",   32'(mem_busy), 0);
        check("cmpl_rd_en",  32'(ram_read_enable), 0);
        check("cmpl_wr_en",  32'(ram_write_enable), 0);
        check("cmpl_mdr",    mdr, exp_mdr);
        check("cmpl_instr",  instr, exp_instr);
        break;
      end else if (i == TIMEOUT) begin
        check("tmo_done",   32'(mem_done), 1);
        check("tmo_buserr", 32'(bus_error), 1);
        check("tmo_busy",   32'(mem_busy), 0);
        check("tmo_rd_en",  32'(ram_read_enable), 0);
        check("tmo_wr_en",  32'(ram_write_enable), 0);
        check("tmo_mdr",    mdr, exp_mdr);
        check("tmo_instr",  instr, exp_instr);
      end else begin
        check("busy_busy",   32'(mem_busy), 1);
        check("busy_rd_en",  32'(ram_read_enable), 32'(rd));
        check("busy_wr_en",  32'(ram_write_enable), 32'(wr));
        check("busy_addr",   32'(ram_addr), 32'(exp_ra));
        check("busy_wdata",  ram_write_data, wd);
        check("busy_done",   32'(mem_done), 0);
        check("busy_buserr", 32'(bus_error), 0);
      end
    end

    clear_req();
    ram_ready = 1'($urandom);           // DONE: must be ignored
    step();
    ram_ready = 1'b0;
    check("post_buserr", 32'(bus_error), 0);
    check("post_aerr",   32'(addr_error), 0);
    check_quiet("post");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clear_req();
    i_or_d = 1'b0; pc = '0; data_addr = '0; write_data = '0;
    ram_read_data = '0; ram_ready = 1'b0;
    #1;
    check("rst_addr",  32'(ram_addr), 0);
    check("rst_wdata", ram_write_data, 0);
    check_quiet("rst");
    step();
    step();
    reset = 1'b0;
    step();
    check_quiet("rst_rel");

    // Fetch with minimum latency.
    do_txn(1, 0, 1, 0, 32'h40, 32'h0, 32'h0, 1, 32'h8C220004);
    // Store with a few wait cycles; instr and mdr must stay put.
    do_txn(0, 1, 0, 1, 32'h80, 32'h1C, 32'hDEADBEEF, 3, 32'h12345678);
    // Misaligned data read.
    do_txn(1, 0, 0, 1, 32'h40, 32'h1E, 32'h0, 1, 32'h0);
    // Read/write conflict on an aligned address.
    do_txn(1, 1, 0, 0, 32'h44, 32'h0, 32'h55, 1, 32'h0);
    // Timeout on a data read.
    do_txn(1, 0, 0, 1, 32'h0, 32'h100, 32'h0, 99, 32'hAAAA5555);
    // ram_ready in the last BUSY cycle beats the timeout.
    do_txn(1, 0, 0, 1, 32'h0, 32'h200, 32'h0, TIMEOUT, 32'hCAFEF00D);
    // ir_write on a store has no effect.
    do_txn(0, 1, 1, 0, 32'h3FC, 32'h0, 32'h0BADF00D, 2, 32'hFFFFFFFF);
    // Read without ir_write only updates mdr.
    do_txn(1, 0, 0, 0, 32'hFFC, 32'h0, 32'h0, 4, 32'h13572468);

    // Reset in the middle of a BUSY access.
    mem_read = 1'b1; ir_write = 1'b1; i_or_d = 1'b0; pc = 32'h48;
    step();
    check("mid_busy", 32'(mem_busy), 1);
    clear_req();
    step();
    #2;
    reset = 1'b1;
    #1;
    exp_mdr   = '0;
    exp_instr = '0;
    check("mid_rst_addr",  32'(ram_addr), 0);
    check("mid_rst_wdata", ram_write_data, 0);
    check_quiet("mid_rst");
    ram_ready = 1'b1;
    step();
    check_quiet("mid_rst_hold");
    reset = 1'b0;
    ram_ready = 1'b0;
    step();
    check_quiet("mid_rst_rel");
    do_txn(1, 0, 1, 0, 32'h40, 32'h0, 32'h0, 1, 32'h8C220004);

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      int          op;
      logic        rd, wr;
      logic [31:0] a_pc, a_da;
      op   = int'($urandom_range(0, 9));
      rd   = (op == 0) || (op < 5);
      wr   = (op == 0) || (op >= 5);
      a_pc = $urandom & 32'h0000_3FFC;
      a_da = $urandom & 32'h0000_3FFC;
      if ($urandom_range(0, 7) == 0) a_pc[1:0] = 2'($urandom);
      if ($urandom_range(0, 7) == 0) a_da[1:0] = 2'($urandom);
      do_txn(rd, wr, 1'($urandom), 1'($urandom), a_pc, a_da, $urandom,
             int'($urandom_range(1, TIMEOUT + 3)), $urandom);
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
        step();
        check_quiet("gap");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
